// File: rtl/ntt_bfly_pipe.sv
// Pipelined radix-2 NTT butterfly over q=3329 (CT forward / GS inverse).
// Twiddle product comes from the local Modmul; valid chain gates its output.
module ntt_modmul #(
  parameter int Q   = 3329,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] r
);
  logic [23:0] prod_d, prod_q;
  logic [11:0] red;

  always_comb begin
    prod_d = 24'(a) * 24'(b);
    red    = 12'(prod_q % 24'(Q));
  end

  always_ff @(posedge clk) prod_q <= prod_d;

  if (LAT == 1) begin : g_l1
    assign r = red;
  end else begin : g_ln
    logic [11:0] dl_d [LAT-1];
    logic [11:0] dl_q [LAT-1];

    always_comb begin
      dl_d[0] = red;
      for (int i = 1; i < LAT - 1; i++) dl_d[i] = dl_q[i-1];
    end

    always_ff @(posedge clk) dl_q <= dl_d;

    assign r = dl_q[LAT-2];
  end
endmodule

module ntt_bfly_pipe #(
  parameter int Q       = 3329,
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        mode,
  input  logic        half,
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic [11:0] w,
  output logic        out_valid,
  output logic [11:0] u,
  output logic [11:0] v,
  output logic        busy,
  output logic        range_err
);
  typedef struct packed {
    logic        mode;
    logic        half;
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] w;
  } op_t;

  typedef struct packed {
    logic        mode;
    logic        half;
    logic [11:0] x;
  } side_t;

  function automatic logic [11:0] mod_add(
    input logic [11:0] x, input logic [11:0] y);
    logic [12:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 13'(Q)) s = s - 13'(Q);
    return 12'(s);
  endfunction

  function automatic logic [11:0] mod_sub(
    input logic [11:0] x, input logic [11:0] y);
    logic [12:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[12]) d = d + 13'(Q);
    return 12'(d);
  endfunction

  // x * 2^-1 mod Q: odd values borrow a Q to become even first
  function automatic logic [11:0] halve(input logic [11:0] x);
    if (x[0]) return 12'((13'(x) + 13'(Q)) >> 1);
    return x >> 1;
  endfunction

  logic        s1_v_d, s1_v_q;
  op_t         s1_d, s1_q;
  logic        s2_v_d, s2_v_q;
  op_t         s2_d, s2_q;
  logic [MUL_LAT-1:0] dl_v_d, dl_v_q;
  side_t       dl_d [MUL_LAT];
  side_t       dl_q [MUL_LAT];
  logic [11:0] p;
  logic        o_v_d, o_v_q;
  logic [11:0] u_d, u_q, v_d, v_q;
  logic        rng_d, rng_q;
  logic [11:0] ru, rv;
  side_t       t;

  ntt_modmul #(.Q(Q), .LAT(MUL_LAT)) u_mul (
    .clk (clk),
    .a   (s2_q.y),
    .b   (s2_q.w),
    .r   (p)
  );

  always_comb begin
    s1_v_d    = in_valid;
    s1_d.mode = mode;
    s1_d.half = half;
    s1_d.x    = a;
    s1_d.y    = b;
    s1_d.w    = w;
    rng_d     = rng_q | (in_valid &
                (a >= 12'(Q) | b >= 12'(Q) | w >= 12'(Q)));
  end

  always_comb begin
    s2_v_d = s1_v_q;
    s2_d   = s1_q;
    if (s1_q.mode) begin
      s2_d.x = mod_add(s1_q.x, s1_q.y);
      s2_d.y = mod_sub(s1_q.x, s1_q.y);
    end
  end

  always_comb begin
    dl_v_d[0]    = s2_v_q;
    dl_d[0].mode = s2_q.mode;
    dl_d[0].half = s2_q.half;
    dl_d[0].x    = s2_q.x;
    for (int i = 1; i < MUL_LAT; i++) begin
      dl_v_d[i] = dl_v_q[i-1];
      dl_d[i]   = dl_q[i-1];
    end
  end

  always_comb begin
    t = dl_q[MUL_LAT-1];
    if (t.mode) begin
      ru = t.x;
      rv = p;
    end else begin
      ru = mod_add(t.x, p);
      rv = mod_sub(t.x, p);
    end
    if (t.half) begin
      ru = halve(ru);
      rv = halve(rv);
    end
    o_v_d = dl_v_q[MUL_LAT-1];
    u_d   = o_v_d ? ru : u_q;
    v_d   = o_v_d ? rv : v_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      dl_v_q <= '0;
      o_v_q  <= 1'b0;
      u_q    <= '0;
      v_q    <= '0;
      rng_q  <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      dl_v_q <= dl_v_d;
      o_v_q  <= o_v_d;
      u_q    <= u_d;
      v_q    <= v_d;
      rng_q  <= rng_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
    dl_q <= dl_d;
  end

  assign out_valid = o_v_q;
  assign u         = u_q;
  assign v         = v_q;
  assign busy      = s1_v_q | s2_v_q | (|dl_v_q) | o_v_q;
  assign range_err = rng_q;
endmodule

// File: tb/tb_ntt_bfly_pipe.sv
// Directed bench for ntt_bfly_pipe: fixed vectors, streaming, reset, range.
// Expected values are hand-computed or from an independent integer model.
module tb_ntt_bfly_pipe;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        mode = 1'b0;
  logic        half = 1'b0;
  logic [11:0] a = '0;
  logic [11:0] b = '0;
  logic [11:0] w = '0;
  logic        out_valid, busy, range_err;
  logic [11:0] u, v;
  int errors = 0;
  int checks = 0;

  int sa [16];
  int sb [16];
  int sw [16];
  bit sm [16];
  bit sh [16];
  int eu [16];
  int ev [16];

  ntt_bfly_pipe #(.Q(Q), .MUL_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .half      (half),
    .a         (a),
    .b         (b),
    .w         (w),
    .out_valid (out_valid),
    .u         (u),
    .v         (v),
    .busy      (busy),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ia, input int ib, input int iw,
                       input bit im, input bit ih);
    in_valid = 1'b1;
    a = 12'(ia);
    b = 12'(ib);
    w = 12'(iw);
    mode = im;
    half = ih;
  endtask

  function automatic int hv(input int x, input bit h);
    if (!h) return x;
    return (x % 2 == 1) ? (x + Q) / 2 : x / 2;
  endfunction

  task automatic ref_bf(input int ia, input int ib, input int iw,
                        input bit im, input bit ih,
                        output int ou, output int ov);
    int p, s, d;
    if (!im) begin
      p = (ib * iw) % Q;
      ou = (ia + p) % Q;
      ov = (ia - p + Q) % Q;
    end else begin
      s = (ia + ib) % Q;
      d = (ia - ib + Q) % Q;
      ou = s;
      ov = (d * iw) % Q;
    end
    ou = hv(ou, ih);
    ov = hv(ov, ih);
  endtask

  task automatic run_single(input string tag, input int ia, input int ib,
                            input int iw, input bit im, input bit ih,
                            input int xu, input int xv);
    drive(ia, ib, iw, im, ih);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk({tag, "_early"}, out_valid, 0);
    tick();
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_u"}, u, xu);
    chk({tag, "_v"}, v, xv);
    tick();
    chk({tag, "_ov_off"}, out_valid, 0);
    chk({tag, "_u_hold"}, u, xu);
    chk({tag, "_v_hold"}, v, xv);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_ov", out_valid, 0);
    chk("rst_u", u, 0);
    chk("rst_v", v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rerr", range_err, 0);
    rst_n = 1'b1;
    tick();

    run_single("ct_basic", 100, 2, 17, 0, 0, 134, 66);
    run_single("ct_wrap1", 3000, 1, 1000, 0, 0, 671, 2000);
    run_single("ct_wrap2", 5, 1, 10, 0, 0, 15, 3324);
    run_single("ct_wrap3", 0, 3328, 3328, 0, 0, 1, 3328);
    run_single("gs_half", 3, 2, 1, 1, 1, 1667, 1665);
    run_single("gs_full", 3, 2, 1, 1, 0, 5, 1);
    run_single("ct_half", 100, 2, 17, 0, 1, 67, 33);

    for (int i = 0; i < 16; i++) begin
      sa[i] = int'($urandom_range(0, Q - 1));
      sb[i] = int'($urandom_range(0, Q - 1));
      sw[i] = int'($urandom_range(0, Q - 1));
      sm[i] = i[0];
      sh[i] = i[1];
      ref_bf(sa[i], sb[i], sw[i], sm[i], sh[i], eu[i], ev[i]);
    end
    chk("st_idle0", busy, 0);
    for (int c = 0; c < 22; c++) begin
      if (c < 16) drive(sa[c], sb[c], sw[c], sm[c], sh[c]);
      else in_valid = 1'b0;
      tick();
      if (c >= 4 && c < 20) begin
        chk($sformatf("st_ov%0d", c - 4), out_valid, 1);
        chk($sformatf("st_u%0d", c - 4), u, eu[c-4]);
        chk($sformatf("st_v%0d", c - 4), v, ev[c-4]);
      end else begin
        chk($sformatf("st_ov_off%0d", c), out_valid, 0);
      end
      chk($sformatf("st_busy%0d", c), busy, (c < 20) ? 1 : 0);
    end

    drive(100, 2, 17, 0, 0);
    tick();
    drive(3000, 1, 1000, 0, 0);
    tick();
    drive(5, 1, 10, 0, 0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mr_ov_pre", out_valid, 1);
    chk("mr_u_pre", u, 134);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ov", out_valid, 0);
    chk("mr_u", u, 0);
    chk("mr_v", v, 0);
    chk("mr_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    run_single("mr_new", 5, 1, 10, 0, 0, 15, 3324);
    chk("mr_rerr", range_err, 0);

    drive(3329, 0, 1, 0, 0);
    chk("re_before", range_err, 0);
    tick();
    in_valid = 1'b0;
    chk("re_set", range_err, 1);
    repeat (6) tick();
    chk("re_drain", busy, 0);
    run_single("re_next", 3, 2, 1, 1, 0, 5, 1);
    chk("re_sticky", range_err, 1);
    rst_n = 1'b0;
    #1;
    chk("re_clear", range_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ntt_bfly_pipe.md
Name: ntt_bfly_pipe

Overview:
- Fully pipelined radix-2 NTT butterfly over q = 3329 with 12-bit coefficients; one butterfly accepted per clock.
- Feeds the team's Modmul, which performs the twiddle multiply (product mod q), and consumes its result.
- Supports Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT) with optional halving for INTT scaling.
- Sits between the coefficient-bank read path and the write-back path of each lane.

Parameters:
- Q, 3329, modulus; all inputs and outputs lie in [0, Q-1].
- MUL_LAT, 2, clock latency of the instantiated Modmul from A/B to R. Must match the Modmul pipeline build option.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a, b, w, mode, half are sampled when high. No backpressure.
- mode  input  1  0 = CT, 1 = GS.
- half  input  1  1 = multiply both outputs by 2^-1 mod Q.
- a  input  12  top coefficient.
- b  input  12  bottom coefficient.
- w  input  12  twiddle factor.
- out_valid  output  1  u/v valid this cycle.
- u  output  12  top result.
- v  output  12  bottom result.
- busy  output  1  high while any operation is in flight.
- range_err  output  1  sticky flag: an input ≥ Q was sampled with in_valid.

Behaviour:
- Reset (async assert, sync release by the existing reset tree):
  - out_valid = 0, u = 0, v = 0, busy = 0, range_err = 0.
  - All pipeline valid bits cleared; in-flight operations are discarded.
  - Data registers need not be reset. Modmul has no reset, so its output is ignored until the valid chain marks it.
- Latency: LAT = MUL_LAT + 3. in_valid in cycle n gives out_valid in cycle n + LAT (default 5).
  - Throughput is 1 per cycle; order is preserved; out_valid mirrors the in_valid pattern delayed by LAT.
- Stage S1: register a, b, w, mode, half and the valid bit.
- Stage S2 (registered):
  - GS: s = (a + b) mod Q; d = (a − b) mod Q.
  - CT: a and b pass through.
- Multiplier operands come from S2 registers: CT multiplies b·w; GS multiplies d·w. The product p returns MUL_LAT cycles later.
  - a (CT) or s (GS), mode, half and valid are carried alongside in a delay line of depth MUL_LAT.
- Final stage (registered to u/v):
  - CT: u = (a + p) mod Q; v = (a − p) mod Q.
  - GS: u = s; v = p.
  - If half = 1, each result x becomes x>>1 when x is even, else (x + Q)>>1.
- Modular add: 13-bit sum, subtract Q if ≥ Q.
- Modular sub: 13-bit difference, add Q if negative. No other reduction is performed.
- u/v hold their last value when out_valid = 0.
- busy = OR of all valid bits in S1 through the final stage.
- range_err: set when in_valid is high and any of a, b, w ≥ Q.
  - Cleared only by reset.
  - The operation still proceeds; its result is unspecified but must remain 12 bits wide.
- mode and half may change every cycle. Each operation uses the values sampled with its own in_valid.
- Reset asserted mid-stream: no out_valid for any pre-reset operation. A new in_valid in the first cycle after release is accepted normally.

Test Plan:
- CT basic: a=100, b=2, w=17, mode=0, half=0 → after 5 cycles out_valid=1, u=134, v=66.
- CT both wraps:
  - a=3000, b=1, w=1000 → u=671, v=2000.
  - a=5, b=1, w=10 → u=15, v=3324.
  - a=0, b=3328, w=3328 → u=1, v=3328.
- GS with halving: a=3, b=2, w=1, mode=1, half=1 → u=1667, v=1665. Same inputs with half=0 → u=5, v=1.
- Streaming: 16 back-to-back ops with random in-range values, alternating mode and half, against a reference model → 16 consecutive out_valid cycles starting at cycle 5, in order, all matching. busy is high from cycle 1 until the last output, then drops.
- Reset mid-flight: issue 3 ops, pull rst_n low asynchronously 2 cycles later → out_valid, u, v, busy fall to 0 immediately and no late out_valid appears. A new op after release completes with LAT=5.
- Range error: a=3329 with in_valid → range_err=1 from the next cycle and stays set through subsequent valid ops until rst_n.
